// File: rtl/mmio_fabric.sv
// mmio_fabric: routes one CPU request at a time to a slave port or to the
// internal error-status page. Slaves that do not answer in time get a bus error.
//
// state  | meaning
// IDLE   | waiting for m_valid; decode and register the request
// ACCESS | s_valid held on the selected port, counting wait cycles
// RESP   | one-cycle m_ready pulse with m_rdata valid
module mmio_fabric #(
  parameter int                       NUM_SLAVES  = 4,
  parameter logic [NUM_SLAVES*16-1:0] SLAVE_PAGES = {16'h6000, 16'h4000, 16'h2000, 16'h0000},
  parameter logic [15:0]              STATUS_PAGE = 16'hF000,
  parameter int                       TIMEOUT     = 255,
  parameter logic [31:0]              ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       m_valid,
  output logic                       m_ready,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  output logic [31:0]                m_rdata,
  input  logic [3:0]                 m_wstrb,
  output logic [NUM_SLAVES-1:0]      s_valid,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  output logic                       irq_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sel_q, sel_d;
  logic [NUM_SLAVES-1:0]   s_valid_q, s_valid_d;
  logic [31:0]             s_addr_q, s_addr_d;
  logic [31:0]             s_wdata_q, s_wdata_d;
  logic [3:0]              s_wstrb_q, s_wstrb_d;
  logic [31:0]             m_rdata_q, m_rdata_d;
  logic [15:0]             wait_q, wait_d;
  logic [15:0]             err_count_q, err_count_d;
  logic [2:0]              err_port_q, err_port_d;
  logic [31:0]             err_addr_q, err_addr_d;
  logic                    irq_q, irq_d;

  logic                    hit_status;
  logic [2:0]              dec_sel;
  logic                    sel_ready;
  logic [31:0]             sel_rdata;
  logic [31:0]             status_rdata;
  logic                    timeout_hit;

  // Descending scan so the lowest matching port index wins.
  always_comb begin
    hit_status = (m_addr[31:16] == STATUS_PAGE);
    dec_sel    = 3'd0;
    for (int i = NUM_SLAVES - 1; i >= 1; i--) begin
      if (SLAVE_PAGES[16*i +: 16] == m_addr[31:16]) dec_sel = 3'(i);
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == 3'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    case (m_addr[15:0])
      16'h0000: status_rdata = {8'h0, 5'h0, err_port_q, err_count_q};
      16'h0004: status_rdata = err_addr_q;
      16'h0008: status_rdata = {16'h0, 8'(NUM_SLAVES), 7'h0, irq_q};
      default:  status_rdata = 32'h0;
    endcase
  end

  // The cycle that would bring the counter to TIMEOUT is the error cycle.
  assign timeout_hit = (wait_q == 16'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    s_valid_d   = s_valid_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_wstrb_d   = s_wstrb_q;
    m_rdata_d   = m_rdata_q;
    wait_d      = wait_q;
    err_count_d = err_count_q;
    err_port_d  = err_port_q;
    err_addr_d  = err_addr_q;
    irq_d       = irq_q;

    case (state_q)
      IDLE: begin
        if (m_valid) begin
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          s_wstrb_d = m_wstrb;
          if (hit_status) begin
            m_rdata_d = status_rdata;
            state_d   = RESP;
            if ((m_wstrb != 4'h0) && (m_addr[15:0] == 16'h0000)) begin
              err_count_d = 16'h0;
              err_port_d  = 3'h0;
              err_addr_d  = 32'h0;
              irq_d       = 1'b0;
            end
          end else begin
            sel_d   = dec_sel;
            wait_d  = 16'h0;
            state_d = ACCESS;
            for (int i = 0; i < NUM_SLAVES; i++) s_valid_d[i] = (dec_sel == 3'(i));
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          m_rdata_d = sel_rdata;
          s_valid_d = '0;
          state_d   = RESP;
        end else if (timeout_hit) begin
          m_rdata_d  = ERR_DATA;
          s_valid_d  = '0;
          err_addr_d = s_addr_q;
          err_port_d = sel_q;
          irq_d      = 1'b1;
          state_d    = RESP;
          if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= 3'h0;
      s_valid_q   <= '0;
      s_addr_q    <= 32'h0;
      s_wdata_q   <= 32'h0;
      s_wstrb_q   <= 4'h0;
      m_rdata_q   <= 32'h0;
      wait_q      <= 16'h0;
      err_count_q <= 16'h0;
      err_port_q  <= 3'h0;
      err_addr_q  <= 32'h0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      s_valid_q   <= s_valid_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wstrb_q   <= s_wstrb_d;
      m_rdata_q   <= m_rdata_d;
      wait_q      <= wait_d;
      err_count_q <= err_count_d;
      err_port_q  <= err_port_d;
      err_addr_q  <= err_addr_d;
      irq_q       <= irq_d;
    end
  end

  assign m_ready = (state_q == RESP);
  assign m_rdata = m_rdata_q;
  assign s_valid = s_valid_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_wstrb = s_wstrb_q;
  assign irq_err = irq_q;

endmodule

// File: tb/tb_mmio_fabric.sv
// Bench for mmio_fabric: vector table through a scoreboard, a responder model
// for the slave ports, and hand-written reset sequences.
module tb_mmio_fabric;
  localparam int          NS  = 4;
  localparam int          TO  = 255;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic             clk = 1'b0;
  logic             reset;
  logic             m_valid, m_ready;
  logic [31:0]      m_addr, m_wdata, m_rdata;
  logic [3:0]       m_wstrb;
  logic [NS-1:0]    s_valid, s_ready;
  logic [31:0]      s_addr, s_wdata;
  logic [3:0]       s_wstrb;
  logic [NS*32-1:0] s_rdata;
  logic             irq_err;

  mmio_fabric dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_wstrb(m_wstrb),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .irq_err(irq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          dly;
    int          port;
    logic [3:0]  extra;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        irq;
    int          lat;
    int          svc;
    logic [3:0]  mask;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] sdata [NS];
  int          n_vec = 0;
  int          n_err = 0;
  int          rsp_delay = -1;
  logic [3:0]  extra_ready = 4'h0;

  logic [15:0] mc = 16'h0;
  logic [2:0]  mp = 3'h0;
  logic [31:0] ma = 32'h0;
  logic        mi = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status(input logic [15:0] off);
    case (off)
      16'h0000: return {13'h0, mp, mc};
      16'h0004: return ma;
      16'h0008: return {16'h0, 8'(NS), 7'h0, mi};
      default:  return 32'h0;
    endcase
  endfunction

  // Slave responder: the active port answers 'rsp_delay' cycles after s_valid rises.
  initial begin
    int         cnt;
    logic [3:0] rdy;
    cnt     = 0;
    s_ready = '0;
    forever begin
      @(posedge clk);
      #1;
      rdy = '0;
      if (s_valid != '0) begin
        for (int i = 0; i < NS; i++)
          if (s_valid[i] && rsp_delay >= 0 && cnt == rsp_delay) rdy[i] = 1'b1;
        cnt++;
      end else begin
        cnt = 0;
      end
      s_ready = rdy | extra_ready;
    end
  end

  task automatic run_txn(input vec_t v);
    exp_t        e, g;
    int          lat, svc;
    logic [3:0]  seen, st_seen;
    logic [31:0] rd, ad_seen, wd_seen;
    logic        irq_s, first;
    rd = '0; irq_s = 1'b0; ad_seen = '0; wd_seen = '0; st_seen = '0;
    if (v.port < 0) begin
      e.rdata = model_status(v.addr[15:0]);
      e.lat = 1; e.svc = 0; e.mask = 4'h0;
      if (v.wstrb != 4'h0 && v.addr[15:0] == 16'h0) begin
        mc = 16'h0; mp = 3'h0; ma = 32'h0; mi = 1'b0;
      end
    end else if (v.dly < 0 || v.dly >= TO) begin
      e.rdata = ERR;
      if (mc != 16'hFFFF) mc = mc + 16'd1;
      mp = 3'(v.port); ma = v.addr; mi = 1'b1;
      e.lat = TO + 1; e.svc = TO; e.mask = 4'(1 << v.port);
    end else begin
      e.rdata = sdata[v.port];
      e.lat = v.dly + 2; e.svc = v.dly + 1; e.mask = 4'(1 << v.port);
    end
    e.irq = mi;
    sb.push_back(e);

    rsp_delay = v.dly; extra_ready = v.extra;
    m_addr = v.addr; m_wdata = v.wdata; m_wstrb = v.wstrb; m_valid = 1'b1;
    lat = -1; svc = 0; seen = '0; first = 1'b1;
    for (int c = 1; c <= 1000 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) m_valid = 1'b0;
      seen |= s_valid;
      if (s_valid != '0) begin
        svc++;
        if (first) begin
          first = 1'b0; ad_seen = s_addr; wd_seen = s_wdata; st_seen = s_wstrb;
        end
      end
      if (m_ready) begin
        lat = c; rd = m_rdata; irq_s = irq_err;
      end
    end
    g = sb.pop_front();
    if (lat < 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got no m_ready, expected m_ready within 1000 cycles", v.name);
    end else begin
      chk({v.name, "_lat"},   32'(lat),   32'(g.lat));
      chk({v.name, "_rdata"}, rd,         g.rdata);
      chk({v.name, "_irq"},   32'(irq_s), 32'(g.irq));
      chk({v.name, "_svcyc"}, 32'(svc),   32'(g.svc));
      chk({v.name, "_svmask"}, 32'(seen), 32'(g.mask));
      if (v.port >= 0) begin
        chk({v.name, "_saddr"},  ad_seen,       v.addr);
        chk({v.name, "_swdata"}, wd_seen,       v.wdata);
        chk({v.name, "_swstrb"}, 32'(st_seen),  32'(v.wstrb));
      end
    end
    @(negedge clk);
    chk({v.name, "_pulse1"}, 32'(m_ready), 32'h0);
    extra_ready = 4'h0; rsp_delay = -1;
  endtask

  vec_t tbl[16];
  vec_t post[2];

  initial begin
    int pulses;
    sdata[0] = 32'h12345678; sdata[1] = 32'h11110001;
    sdata[2] = 32'h22220002; sdata[3] = 32'h33330003;
    s_rdata = {sdata[3], sdata[2], sdata[1], sdata[0]};

    tbl[0]  = '{"wr_p1_d3",    32'h2000_0000, 32'h41,       4'b0001, 3,   1, 4'h0};
    tbl[1]  = '{"rd_p0_d0",    32'h0000_0100, 32'h0,        4'b0000, 0,   0, 4'h0};
    tbl[2]  = '{"rd_p3_d1",    32'h6000_1234, 32'h0,        4'b0000, 1,   3, 4'h0};
    tbl[3]  = '{"rd_dflt_d2",  32'h1234_0000, 32'h0,        4'b0000, 2,   0, 4'h0};
    tbl[4]  = '{"st8_clean",   32'hF000_0008, 32'h0,        4'b0000, -1, -1, 4'h0};
    tbl[5]  = '{"rd_p2_to",    32'h4000_0000, 32'h0,        4'b0000, -1,  2, 4'h0};
    tbl[6]  = '{"st0_err",     32'hF000_0000, 32'h0,        4'b0000, -1, -1, 4'h0};
    tbl[7]  = '{"st4_err",     32'hF000_0004, 32'h0,        4'b0000, -1, -1, 4'h0};
    tbl[8]  = '{"st8_err",     32'hF000_0008, 32'h0,        4'b0000, -1, -1, 4'h0};
    tbl[9]  = '{"stC_zero",    32'hF000_000C, 32'h0,        4'b0000, -1, -1, 4'h0};
    tbl[10] = '{"st4_wr_ign",  32'hF000_0004, 32'hFFFFFFFF, 4'b1111, -1, -1, 4'h0};
    tbl[11] = '{"st0_clear",   32'hF000_0000, 32'h1,        4'b0001, -1, -1, 4'h0};
    tbl[12] = '{"st0_cleared", 32'hF000_0000, 32'h0,        4'b0000, -1, -1, 4'h0};
    tbl[13] = '{"p1_rdy_at_to", 32'h2000_0040, 32'h5A5A0000, 4'b1100, TO - 1, 1, 4'b0100};
    tbl[14] = '{"st0_no_err",  32'hF000_0000, 32'h0,        4'b0000, -1, -1, 4'h0};
    tbl[15] = '{"p1_rdy_late", 32'h2000_0080, 32'h0,        4'b0000, TO,  1, 4'h0};

    post[0] = '{"post_p3_d0",  32'h6000_0000, 32'h77,       4'b1111, 0,   3, 4'h0};
    post[1] = '{"post_st0",    32'hF000_0000, 32'h0,        4'b0000, -1, -1, 4'h0};

    reset = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_ready", 32'(m_ready), 32'h0);
    chk("rst_s_valid", 32'(s_valid), 32'h0);
    chk("rst_m_rdata", m_rdata, 32'h0);
    chk("rst_irq",     32'(irq_err), 32'h0);
    chk("rst_s_addr",  s_addr, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_txn(tbl[i]);

    // Reset in the middle of an ACCESS to port 3 while an error is pending.
    chk("pre_rst_irq",  32'(irq_err), 32'(mi));
    chk("hold_m_rdata", m_rdata, ERR);
    rsp_delay = -1;
    m_addr = 32'h6000_0010; m_wdata = 32'hCAFE; m_wstrb = 4'hF; m_valid = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    chk("mid_sv", 32'(s_valid), 32'h8);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_s_valid", 32'(s_valid), 32'h0);
    chk("mrst_m_ready", 32'(m_ready), 32'h0);
    chk("mrst_m_rdata", m_rdata, 32'h0);
    chk("mrst_irq",     32'(irq_err), 32'h0);
    chk("mrst_s_addr",  s_addr, 32'h0);
    chk("mrst_s_wdata", s_wdata, 32'h0);
    chk("mrst_s_wstrb", 32'(s_wstrb), 32'h0);
    reset = 1'b0;
    mc = 16'h0; mp = 3'h0; ma = 32'h0; mi = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_ready) pulses++;
    end
    chk("mrst_no_ready", 32'(pulses), 32'h0);

    for (int i = 0; i < 2; i++) run_txn(post[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion before 2 ms");
    $fatal(1);
  end

endmodule
